// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory controller.
package dmem_pkg;

  localparam int unsigned DEF_LATENCY     = 4;
  localparam int unsigned DEF_DEPTH_WORDS = 256;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Request captured in IDLE and replayed when the access fires.
  typedef struct packed {
    op_t               op;
    logic [WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read that holds
// its value until the next read or reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller for the MEM stage: stalls the pipeline
// for a fixed access latency and returns registered load data.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEF_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              stall_o,
  output logic              misalign_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  req_t             req_q;
  logic             latch;
  logic             arr_we;
  logic             arr_re;
  logic             req;
  logic             aligned;
  logic             unused_addr;

  assign req         = MemRead_i | MemWrite_i;
  assign aligned     = (addr_i[1:0] == 2'b00);
  // Upper address bits are dropped so addresses wrap onto the array.
  assign unused_addr = ^addr_i[WORD_W-1:IDX_W+2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        idx_q <= addr_i[IDX_W+1:2];
        req_q <= '{op: (MemWrite_i ? OP_WRITE : OP_READ), wdata: data_i};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch      = 1'b0;
    arr_we     = 1'b0;
    arr_re     = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (aligned) begin
            stall_o = 1'b1;
            latch   = 1'b1;
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = BUSY;
          end else begin
            misalign_o = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          if (req_q.op == OP_WRITE) begin
            arr_we = 1'b1;
          end else begin
            arr_re = 1'b1;
          end
        end
      end
      DONE: begin
        // Inputs still carry the completed request; never re-accept here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A reset on the firing edge must not commit a pending store.
  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (arr_we & ~rst_i),
    .re    (arr_re),
    .idx   (idx_q),
    .wdata (req_q.wdata),
    .rdata (data_o)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: table of load/store vectors plus reset corners.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned LAT = 4;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        stall;
  logic        mis;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  dmem_ctrl #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .MemRead_i  (rd),
    .MemWrite_i (wr),
    .addr_i     (addr),
    .data_i     (din),
    .data_o     (dout),
    .stall_o    (stall),
    .misalign_o (mis)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    logic [31:0] prev;
    int n;
    @(posedge clk);
    #1;
    prev = dout;
    rd   = v.rd;
    wr   = v.wr;
    addr = v.addr;
    din  = v.wdata;
    if (v.addr[1:0] != 2'b00) begin
      @(negedge clk);
      chk({v.name, "_misalign"}, 32'(mis), 32'd1);
      chk({v.name, "_nostall"}, 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      rd = 1'b0;
      wr = 1'b0;
      @(negedge clk);
      chk({v.name, "_data"}, dout, v.exp);
      chk({v.name, "_mis_clear"}, 32'(mis), 32'd0);
      chk({v.name, "_idle"}, 32'(dut.state_q), 32'(IDLE));
    end else begin
      n = 0;
      @(negedge clk);
      while (stall === 1'b1 && n < 20) begin
        chk({v.name, "_hold"}, dout, prev);
        chk({v.name, "_mis_busy"}, 32'(mis), 32'd0);
        n++;
        @(negedge clk);
      end
      chk({v.name, "_stall_len"}, 32'(n), 32'(LAT + 1));
      chk({v.name, "_data"}, dout, v.exp);
      @(posedge clk);
      #1;
      rd = 1'b0;
      wr = 1'b0;
      @(negedge clk);
      chk({v.name, "_no_retrig"}, 32'(stall), 32'd0);
      chk({v.name, "_data_keep"}, dout, v.exp);
    end
  endtask

  initial begin
    clk  = 1'b0;
    rst  = 1'b1;
    rd   = 1'b0;
    wr   = 1'b0;
    addr = '0;
    din  = '0;

    for (int i = 0; i < 256; i++) dut.u_array.mem[i] = 32'h0;
    dut.u_array.mem[5]   = 32'hDEADBEEF;
    dut.u_array.mem[255] = 32'h0BADCAFE;

    vecs[0]  = '{"rd_14",      1'b1, 1'b0, 32'h0000_0014, 32'h0,          32'hDEADBEEF};
    vecs[1]  = '{"wr_20",      1'b0, 1'b1, 32'h0000_0020, 32'h12345678,   32'hDEADBEEF};
    vecs[2]  = '{"rd_20",      1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'h12345678};
    vecs[3]  = '{"rd_420",     1'b1, 1'b0, 32'h0000_0420, 32'h0,          32'h12345678};
    vecs[4]  = '{"wr_420",     1'b0, 1'b1, 32'h0000_0420, 32'hCAFEF00D,   32'h12345678};
    vecs[5]  = '{"rd_20b",     1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'hCAFEF00D};
    vecs[6]  = '{"rdwr_8",     1'b1, 1'b1, 32'h0000_0008, 32'hA5A5A5A5,   32'hCAFEF00D};
    vecs[7]  = '{"rd_8",       1'b1, 1'b0, 32'h0000_0008, 32'h0,          32'hA5A5A5A5};
    vecs[8]  = '{"mis_rd_13",  1'b1, 1'b0, 32'h0000_0013, 32'h0,          32'hA5A5A5A5};
    vecs[9]  = '{"mis_wr_2",   1'b0, 1'b1, 32'h0000_0002, 32'h11111111,   32'hA5A5A5A5};
    vecs[10] = '{"rd_top",     1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          32'h0BADCAFE};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_data", dout, 32'h0);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_mis", 32'(mis), 32'd0);
    end

    foreach (vecs[i]) apply_vec(vecs[i]);

    chk("mem_word2", dut.u_array.mem[2], 32'hA5A5A5A5);
    chk("mem_word8", dut.u_array.mem[8], 32'hCAFEF00D);
    chk("mem_word0_untouched", dut.u_array.mem[0], 32'h0);

    // Store aborted by a reset in the second BUSY cycle.
    @(posedge clk);
    #1;
    wr   = 1'b1;
    addr = 32'h0000_001C;
    din  = 32'hFFFFFFFF;
    @(negedge clk);
    chk("abort_req_stall", 32'(stall), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr  = 1'b0;
    @(negedge clk);
    chk("abort_busy_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_data", dout, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_quiet", 32'(stall), 32'd0);
    end
    chk("abort_word7", dut.u_array.mem[7], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
